cond_logic: RTL

- Conditional-execution stage directly downstream of the control-unit decoder in the single-cycle ARM processor.
- Holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against the registered flags.
- Gates the decoder's write and branch strobes (PCS, Branch, RegW, MemW, BrL) so that annulled instructions have no architectural effect.
- Keeps two saturating counters, executed and annulled, for lab performance observation.

---
 rtl/cond_pkg.sv | 29 ++
 rtl/cond_check.sv | 39 +++
 rtl/cond_logic.sv | 91 +++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution stage: condition encodings
// and flag bit positions within the {N,Z,C,V} nibble.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator: (Cond, Flags) -> CondEx.
// The 1111 encoding executes unconditionally, like AL.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b1;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV flag register, condition check, strobe
// gating, and saturating executed/annulled instruction counters.
module cond_logic #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             Branch,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             BrL,
    input  logic             CntClr,
    output logic             CondEx,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             LinkWrite,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SkipCnt
);
    import cond_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
    logic             cond_ex;

    // Evaluated against the registered flags, so a flag-setting instruction
    // tests the flags that existed before it executes.
    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    assign CondEx    = cond_ex;
    assign PCSrc     = (PCS | Branch) & cond_ex;
    assign RegWrite  = RegW & cond_ex;
    assign MemWrite  = MemW & cond_ex;
    assign LinkWrite = BrL & cond_ex;
    assign Flags     = flags_q;
    assign ExecCnt   = exec_cnt_q;
    assign SkipCnt   = skip_cnt_q;

    always_comb begin
        flags_d = flags_q;
        if (cond_ex) begin
            if (FlagW[1]) begin
                flags_d[FLAG_N] = ALUFlags[FLAG_N];
                flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
            end
            if (FlagW[0]) begin
                flags_d[FLAG_C] = ALUFlags[FLAG_C];
                flags_d[FLAG_V] = ALUFlags[FLAG_V];
            end
        end
    end

    always_comb begin
        exec_cnt_d = exec_cnt_q;
        skip_cnt_d = skip_cnt_q;
        if (CntClr) begin
            exec_cnt_d = '0;
            skip_cnt_d = '0;
        end else if (cond_ex) begin
            if (exec_cnt_q != CNT_MAX) exec_cnt_d = exec_cnt_q + CNT_W'(1);
        end else begin
            if (skip_cnt_q != CNT_MAX) skip_cnt_d = skip_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q    <= 4'b0000;
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else begin
            flags_q    <= flags_d;
            exec_cnt_q <= exec_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

endmodule
